mov_engine: RTL
===============

# mov_engine

Parametrised block-move engine for the MIX core, and the next generation of the existing single-rate move unit. It executes MOVE-style copies of `len` consecutive memory words from a source address to a destination address through one shared, synchronous memory port. Read latency is configurable. An optional descending mode supports safe overlapping copies. It sits between the instruction sequencer, which supplies `start`, addresses and length and consumes `done`/`dst_out` to update rI1, and the main word memory.

## Interface
- WORD_W, 31: memory word width (sign + 5×6-bit bytes).
- ADDR_W, 12: address width; all address arithmetic is modulo 2^ADDR_W.
- LEN_W, 6: length width; maximum move is 2^LEN_W−1 words.
- RD_LAT, 1: memory read latency in cycles, ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only when idle.
- src  in  ADDR_W  first source address, captured on accepted start.
- dst  in  ADDR_W  first destination address, captured on accepted start.
- len  in  LEN_W  word count, captured on accepted start.
- dir  in  1  0 = ascending, 1 = descending; present only with MOV_BACKWARD_EN.
- busy  out  1  high while a move is in progress.
- done  out  1  one-cycle pulse on completion.
- dst_out  out  ADDR_W  dst + len, updated with done and held until the next done.
- mem_addr  out  ADDR_W  memory address.
- mem_re  out  1  read strobe.
- mem_rdata  in  WORD_W  read data, valid exactly RD_LAT cycles after the mem_re cycle.
- mem_we  out  1  write strobe.
- mem_wdata  out  WORD_W  write data.

## Operation
- States: IDLE, READ, WAIT, WRITE, FIN.
- IDLE: start=1 captures src/dst/len/dir and clears index i.
  - len=0 → FIN.
  - Otherwise → READ.
- READ: mem_re=1, mem_addr=src+k. Ascending: k=i. Descending: k=len−1−i. Go to WAIT.
- WAIT: held RD_LAT cycles. mem_rdata is captured into the hold register on the last WAIT cycle. Then → WRITE.
- WRITE: mem_we=1, mem_addr=dst+k, mem_wdata=hold register. i increments.
  - i+1==len → FIN.
  - Otherwise → READ.
- FIN: done=1, dst_out=dst+len (ADDR_W bits, wraps), then → IDLE.
- mem_re and mem_we are never high together. mem_addr is 0 when neither strobe is high.
- start while not in IDLE is ignored; no queuing.
- Overlap: the ascending copy is word-sequential, so dst=src+1 replicates word[src] across the range, matching MIX MOVE semantics. The descending copy preserves data when dst>src.
- Reset values: busy=0, done=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, dst_out=0, state=IDLE.
- rst_n low mid-move aborts the move on that edge. No further strobes are issued and done is not pulsed.

## Timing
- Accepted start at cycle 0. The first READ is at cycle 1.
- Each word costs RD_LAT+2 cycles.
- For len=N≥1, the last WRITE is at cycle N·(RD_LAT+2), and done is at the cycle after it.
- For len=0, done is at cycle 1 with zero memory strobes.
- busy is high from cycle 1 through the last WRITE. It is low in the done cycle, so a new start may be issued in the done cycle's following cycle (IDLE).

## Configuration
- MOV_BACKWARD_EN defined: the dir port exists and descending addressing is supported.
- MOV_BACKWARD_EN undefined: the dir port is absent, behaviour is ascending-only, and the index-reversal subtractor is not built.

## Structure
- Shared package `mix_pkg`:
  - WORD_W, ADDR_W, LEN_W defaults.
  - mov state enum (IDLE/READ/WAIT/WRITE/FIN).
  - MIX word type.
- One sub-module, `mov_addr_gen`: holds base/index/direction and produces the src/dst offset addresses combinationally from registered index.

## Test plan
- mem[100]=12345, mem[101]=1245, src=100, dst=200, len=2, RD_LAT=1:
  - mem[200]=12345, mem[201]=1245.
  - done at cycle 7, dst_out=202, busy low at done.
- len=0:
  - done at cycle 1.
  - mem_re/mem_we never asserted.
  - dst_out=dst.
- Overlap ascending, src=100, dst=101, len=3, mem[100]=7:
  - mem[101..103]=7.
- MOV_BACKWARD_EN, dir=1, src=100, dst=101, len=3, mem[100..102]=1,2,3:
  - mem[101..103]=1,2,3.
  - First write address is 103.
- RD_LAT=3, src=4094, dst=4095, len=3:
  - Addresses wrap to 0/1.
  - 5 cycles per word.
  - dst_out=2.
- Second start pulsed mid-move is ignored. rst_n low at cycle 4 of a len=5 move:
  - No strobes after reset.
  - No done pulse.
  - All outputs at reset values.

Source files
------------

// File: rtl/mix_pkg.sv
// mix_pkg: shared definitions for the MIX core datapath blocks.
//   WORD_W / ADDR_W / LEN_W : default word, address and move-length widths
//   mov_state_e             : block-move engine sequencing states
//   mix_word_t              : one MIX word (sign + 5 x 6-bit bytes)
package mix_pkg;

    localparam int WORD_W = 31;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_FIN
    } mov_state_e;

    typedef logic [WORD_W-1:0] mix_word_t;

endpackage

// File: rtl/mov_addr_gen.sv
// mov_addr_gen: holds the captured move descriptor (src/dst base, length,
// direction) and the word index, and forms the current source/destination
// addresses combinationally from the registered index.
// Optional feature macro: MOV_BACKWARD_EN (adds i_dir and index reversal).
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_load           capture descriptor, clear index
//   i_inc            advance index by one word
//   i_src/i_dst/i_len descriptor inputs (i_dir when MOV_BACKWARD_EN)
//   o_src_addr       src + k
//   o_dst_addr       dst + k
//   o_dst_end        dst + len (modulo 2^ADDR_W)
//   o_last           current index is the final word
module mov_addr_gen
    import mix_pkg::*;
#(
    parameter int ADDR_W = mix_pkg::ADDR_W,
    parameter int LEN_W  = mix_pkg::LEN_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
`ifdef MOV_BACKWARD_EN
    input  logic              i_dir,
`endif
    output logic [ADDR_W-1:0] o_src_addr,
    output logic [ADDR_W-1:0] o_dst_addr,
    output logic [ADDR_W-1:0] o_dst_end,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  w_k;
`ifdef MOV_BACKWARD_EN
    logic              r_dir;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_src <= '0;
            r_dst <= '0;
            r_len <= '0;
            r_idx <= '0;
`ifdef MOV_BACKWARD_EN
            r_dir <= 1'b0;
`endif
        end else if (i_load) begin
            r_src <= i_src;
            r_dst <= i_dst;
            r_len <= i_len;
            r_idx <= '0;
`ifdef MOV_BACKWARD_EN
            r_dir <= i_dir;
`endif
        end else if (i_inc) begin
            r_idx <= r_idx + LEN_W'(1);
        end
    end

    // Descending walks the block from its top word down so an overlapping
    // copy with dst > src never reads a word it has already overwritten.
`ifdef MOV_BACKWARD_EN
    assign w_k = r_dir ? (r_len - LEN_W'(1) - r_idx) : r_idx;
`else
    assign w_k = r_idx;
`endif

    assign o_src_addr = r_src + ADDR_W'(w_k);
    assign o_dst_addr = r_dst + ADDR_W'(w_k);
    assign o_dst_end  = r_dst + ADDR_W'(r_len);
    assign o_last     = ((r_idx + LEN_W'(1)) == r_len);

endmodule

// File: rtl/mov_engine.sv
// mov_engine: MIX MOVE block-copy engine. Copies len words from src to dst
// through one shared synchronous memory port, one word at a time:
// READ (1 cycle), WAIT (RD_LAT cycles), WRITE (1 cycle).
// Optional feature macro: MOV_BACKWARD_EN (i_dir port, descending copies).
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start               move request, honoured only in IDLE
//   i_src, i_dst, i_len   move descriptor (i_dir when MOV_BACKWARD_EN)
//   o_busy                move in progress (READ/WAIT/WRITE)
//   o_done                one-cycle completion pulse
//   o_dst_out             dst + len, valid with o_done and held after
//   o_mem_addr            memory address, 0 when no strobe is active
//   o_mem_re/i_mem_rdata  read strobe / data (valid RD_LAT cycles later)
//   o_mem_we/o_mem_wdata  write strobe / data
module mov_engine
    import mix_pkg::*;
#(
    parameter int WORD_W = mix_pkg::WORD_W,
    parameter int ADDR_W = mix_pkg::ADDR_W,
    parameter int LEN_W  = mix_pkg::LEN_W,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
`ifdef MOV_BACKWARD_EN
    input  logic              i_dir,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_dst_out,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_re,
    input  logic [WORD_W-1:0] i_mem_rdata,
    output logic              o_mem_we,
    output logic [WORD_W-1:0] o_mem_wdata
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    mov_state_e        r_state;
    logic [CNT_W-1:0]  r_wcnt;
    logic [WORD_W-1:0] r_hold;
    logic [ADDR_W-1:0] r_dst_out;

    logic              w_load;
    logic              w_inc;
    logic              w_last;
    logic [ADDR_W-1:0] w_src_addr;
    logic [ADDR_W-1:0] w_dst_addr;
    logic [ADDR_W-1:0] w_dst_end;

    assign w_load = (r_state == S_IDLE) && i_start;
    assign w_inc  = (r_state == S_WRITE);

    mov_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_inc      (w_inc),
        .i_src      (i_src),
        .i_dst      (i_dst),
        .i_len      (i_len),
`ifdef MOV_BACKWARD_EN
        .i_dir      (i_dir),
`endif
        .o_src_addr (w_src_addr),
        .o_dst_addr (w_dst_addr),
        .o_dst_end  (w_dst_end),
        .o_last     (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_wcnt    <= '0;
            r_hold    <= '0;
            r_dst_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_len == '0) begin
                            // Empty move: dst + 0 is just the requested dst.
                            r_dst_out <= i_dst;
                            r_state   <= S_FIN;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_wcnt  <= CNT_W'(RD_LAT - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data lands in the last WAIT cycle.
                    if (r_wcnt == '0) begin
                        r_hold  <= i_mem_rdata;
                        r_state <= S_WRITE;
                    end else begin
                        r_wcnt <= r_wcnt - CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_dst_out <= w_dst_end;
                        r_state   <= S_FIN;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state flop, so reset forces every
    // strobe low on the same edge that aborts the move.
    assign o_busy      = (r_state == S_READ) || (r_state == S_WAIT) || (r_state == S_WRITE);
    assign o_done      = (r_state == S_FIN);
    assign o_dst_out   = r_dst_out;
    assign o_mem_re    = (r_state == S_READ);
    assign o_mem_we    = (r_state == S_WRITE);
    assign o_mem_addr  = (r_state == S_READ)  ? w_src_addr :
                         (r_state == S_WRITE) ? w_dst_addr : '0;
    assign o_mem_wdata = (r_state == S_WRITE) ? r_hold : '0;

endmodule
